pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Sequential PC register and instruction-fetch controller.
//   Sits upstream of decode and downstream of the branch-resolution logic.
//   Fetches words from instruction memory over a req/ack handshake and presents them to decode over a valid/ready handshake.
//   Consumes isBranch/pcLabel from the branch unit and supplies the pc that unit uses for its link (pc+4) computation.
// PARAMETERS
//   PC_W      12      PC / byte-address width
//   INSTR_W   32      instruction word width
//   RESET_PC  12'h000 PC loaded on reset
//   PC_STEP   12'd4   sequential increment (bytes)
//   HALT_OP   6'd63   opcode (instr[31:26]) that stops fetching
// PORTS
//   clk         in   1        clock, rising edge
//   rst         in   1        asynchronous active-low reset (asserted at 0)
//   imemReq     out  1        fetch request, held until imemAck
//   imemAddr    out  PC_W     fetch byte address, stable while imemReq=1
//   imemAck     in   1        read data valid this cycle (1..N cycle latency)
//   imemData    in   INSTR_W  instruction word, sampled when imemAck=1
//   instrValid  out  1        instr/pc valid to decode
//   instrReady  in   1        decode accepts instr this cycle
//   instr       out  INSTR_W  held instruction word
//   pc          out  PC_W     address of held instruction
//   isBranch    in   1        branch taken; meaningful only on valid&&ready
//   pcLabel     in   PC_W     taken-branch target (low 12 bits of branch-unit label)
//   halted      out  1        HALT_OP accepted; fetch stopped
// BEHAVIOUR
//   Reset (rst=0, async): state=FETCH, pc=RESET_PC, instr=0.
//     Reset values: imemReq=0, instrValid=0, halted=0, imemAddr=RESET_PC.
//   States:
//     FETCH: imemReq=1, imemAddr=pc, go WAIT next cycle.
//     WAIT:  imemReq=1, addr held.
//       On imemAck: instr<=imemData, go HOLD.
//       If imemData[31:26]==HALT_OP, go HALTED instead; instr is still loaded.
//     HOLD:  instrValid=1, instr and pc held stable.
//       On instrReady: if isBranch, pc<=pcLabel; else pc<=pc+PC_STEP. Go FETCH.
//     HALTED: instrValid=0, imemReq=0, halted=1. Terminal; left only by reset.
//   Latency: first imemReq 1 cycle after reset release.
//     Ack to instrValid: 1 cycle.
//     Accept to next imemReq: 1 cycle.
//   PC arithmetic: mod 2^PC_W; 12'hFFC+4 wraps to 12'h000 with no flag.
//     pcLabel is used as-is; low 2 bits are not forced to zero.
//   isBranch and pcLabel are ignored in FETCH, WAIT and HALTED, and in HOLD while instrReady=0.
//   imemAck outside WAIT is ignored, with no state change.
//   Reset mid-fetch (WAIT): request dropped.
//     Memory is on the same reset, so no stale ack is expected.
//     If a stale ack does arrive after reset, it lands in FETCH and is ignored.
//   instrReady=1 while instrValid=0: no effect.
//   Max throughput: 1 instruction per 3 cycles (FETCH, WAIT, HOLD), with ack latency 1 and ready held high.
//   All outputs are registered or decoded from the state register only. No comb path in->out.
// STRUCTURE
//   Shared package (kgp_pkg): PC_W, INSTR_W, HALT_OP, PC_STEP, plus the fetch state encoding:
//     FETCH=2'd0, WAIT=2'd1, HOLD=2'd2, HALTED=2'd3.
//   Single module. The next-PC mux is inline; no sub-module.
// TESTING
//   1 Reset, then ack always next cycle, ready=1, isBranch=0:
//     pc seq 000,004,008; instrValid once per 3 cycles.
//   2 Ack delayed 4 cycles at pc=004:
//     imemAddr=004 held 5 cycles; instr appears 1 cycle after ack.
//   3 HOLD at pc=010 with ready=0 for 3 cycles, isBranch=1 throughout:
//     pc and instr stable, no redirect.
//     Then ready=1, pcLabel=040: next imemAddr=040.
//   4 pc=FFC, accept with isBranch=0: next imemAddr=000.
//   5 Data {6'd63,26'd0} returned at pc=020:
//     halted=1, imemReq=0 forever, instrValid=0.
//   6 rst=0 asserted in WAIT (async, mid-cycle):
//     imemReq drops immediately, pc=000.
//     After release, a stray imemAck before the first request is ignored.

Source files
------------

// File: rtl/kgp_pkg.sv
// rtl/kgp_pkg.sv - shared widths, constants and fetch-state encoding for the PC/fetch unit
package kgp_pkg;

   localparam int                PC_W     = 12;
   localparam int                INSTR_W  = 32;
   localparam logic [PC_W-1:0]   RESET_PC = 12'h000;
   localparam logic [PC_W-1:0]   PC_STEP  = 12'd4;
   localparam logic [5:0]        HALT_OP  = 6'd63;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      WAIT   = 2'd1,
      HOLD   = 2'd2,
      HALTED = 2'd3
   } fetch_state_e;

   function automatic logic is_halt(input logic [INSTR_W-1:0] word);
      return word[INSTR_W-1 -: 6] == HALT_OP;
   endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and instruction-fetch controller (imem req/ack in, decode valid/ready out)
module pc_fetch_unit
   import kgp_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   output logic               imemReq,
   output logic [PC_W-1:0]    imemAddr,
   input  logic               imemAck,
   input  logic [INSTR_W-1:0] imemData,
   output logic               instrValid,
   input  logic               instrReady,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pc,
   input  logic               isBranch,
   input  logic [PC_W-1:0]    pcLabel,
   output logic               halted
);

   fetch_state_e       state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               req_q, req_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         req_q   <= req_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   state_d = WAIT;
         WAIT:    if (imemAck) state_d = is_halt(imemData) ? HALTED : HOLD;
         HOLD:    if (instrReady) state_d = FETCH;
         HALTED:  state_d = HALTED;
         default: state_d = FETCH;
      endcase
   end

   // Next-PC mux: branch target taken verbatim, sequential step wraps mod 2^PC_W.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      if (state_q == WAIT && imemAck) begin
         instr_d = imemData;
      end
      if (state_q == HOLD && instrReady) begin
         pc_d = isBranch ? pcLabel : pc_q + PC_STEP;
      end
   end

   // Request is registered so it stays low in the FETCH cycle that follows reset.
   always_comb begin
      req_d      = (state_d == FETCH) || (state_d == WAIT);
      imemReq    = req_q;
      imemAddr   = pc_q;
      instrValid = (state_q == HOLD);
      halted     = (state_q == HALTED);
      instr      = instr_q;
      pc         = pc_q;
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
   import kgp_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               imemReq;
   logic [PC_W-1:0]    imemAddr;
   logic               imemAck = 1'b0;
   logic [INSTR_W-1:0] imemData = '0;
   logic               instrValid;
   logic               instrReady = 1'b0;
   logic [INSTR_W-1:0] instr;
   logic [PC_W-1:0]    pc;
   logic               isBranch = 1'b0;
   logic [PC_W-1:0]    pcLabel = '0;
   logic               halted;

   int tests = 0;
   int fails = 0;

   localparam logic [31:0] HALT_WORD = {6'd63, 26'd0};

   pc_fetch_unit dut (
      .clk(clk), .rst(rst),
      .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
      .instrValid(instrValid), .instrReady(instrReady), .instr(instr), .pc(pc),
      .isBranch(isBranch), .pcLabel(pcLabel), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      imemAck = 1'b0;
      instrReady = 1'b0;
      isBranch = 1'b0;
      #1;
      check("rst_req", 32'(imemReq), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   // Entered in the FETCH cycle; junk branch/ready inputs must be ignored until HOLD.
   task automatic fetch_hold(input logic [11:0] addr, input logic [31:0] data, input int delay);
      instrReady = 1'b1;
      isBranch = 1'b1;
      pcLabel = 12'h3A8;
      for (int i = 0; i < delay; i++) begin
         check("req_held", 32'(imemReq), 32'd1);
         check("addr_held", 32'(imemAddr), 32'(addr));
         check("no_valid_in_fetch", 32'(instrValid), 32'd0);
         tick();
      end
      check("req_last", 32'(imemReq), 32'd1);
      check("addr_last", 32'(imemAddr), 32'(addr));
      instrReady = 1'b0;
      isBranch = 1'b0;
      imemAck = 1'b1;
      imemData = data;
      tick();
      imemAck = 1'b0;
      check("hold_valid", 32'(instrValid), 32'd1);
      check("hold_instr", instr, data);
      check("hold_pc", 32'(pc), 32'(addr));
      check("hold_req_low", 32'(imemReq), 32'd0);
   endtask

   task automatic accept(input logic br, input logic [11:0] lbl, input logic [11:0] nxt);
      instrReady = 1'b1;
      isBranch = br;
      pcLabel = lbl;
      tick();
      instrReady = 1'b0;
      isBranch = 1'b0;
      check("acc_valid_low", 32'(instrValid), 32'd0);
      check("acc_next_req", 32'(imemReq), 32'd1);
      check("acc_next_addr", 32'(imemAddr), 32'(nxt));
   endtask

   initial begin
      // Reset state
      #12;
      check("reset_req", 32'(imemReq), 32'd0);
      check("reset_valid", 32'(instrValid), 32'd0);
      check("reset_halted", 32'(halted), 32'd0);
      check("reset_addr", 32'(imemAddr), 32'h000);
      check("reset_pc", 32'(pc), 32'h000);
      check("reset_instr", instr, 32'h0);

      // 1: single-cycle ack, ready high, sequential pc
      @(negedge clk);
      rst = 1'b1;
      instrReady = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         check("t1_req", 32'(imemReq), 32'd1);
         check("t1_addr", 32'(imemAddr), 32'(4 * k));
         imemAck = 1'b1;
         imemData = 32'h1000_0000 + 32'(k);
         tick();
         imemAck = 1'b0;
         check("t1_valid", 32'(instrValid), 32'd1);
         check("t1_pc", 32'(pc), 32'(4 * k));
         check("t1_instr", instr, 32'h1000_0000 + 32'(k));
         tick();
         check("t1_fetch_valid", 32'(instrValid), 32'd0);
         check("t1_fetch_addr", 32'(imemAddr), 32'(4 * k + 4));
         tick();
      end

      // 2: delayed ack at 004, ack in HOLD ignored
      do_reset();
      imemAck = 1'b1;
      imemData = 32'h2000_0001;
      tick();
      imemAck = 1'b0;
      imemAck = 1'b1;
      imemData = 32'hDEAD_BEEF;
      tick();
      imemAck = 1'b0;
      check("t2_ack_hold_instr", instr, 32'h2000_0001);
      check("t2_ack_hold_valid", 32'(instrValid), 32'd1);
      accept(1'b0, 12'h000, 12'h004);
      fetch_hold(12'h004, 32'h2000_0004, 5);
      accept(1'b0, 12'h000, 12'h008);
      fetch_hold(12'h008, 32'h2000_0008, 1);
      accept(1'b0, 12'h000, 12'h00C);
      fetch_hold(12'h00C, 32'h2000_000C, 1);
      accept(1'b0, 12'h000, 12'h010);
      fetch_hold(12'h010, 32'h2000_0010, 1);

      // 3: stalled HOLD with branch asserted, then redirect
      isBranch = 1'b1;
      pcLabel = 12'h080;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_stall_valid", 32'(instrValid), 32'd1);
         check("t3_stall_pc", 32'(pc), 32'h010);
         check("t3_stall_instr", instr, 32'h2000_0010);
      end
      accept(1'b1, 12'h040, 12'h040);
      fetch_hold(12'h040, 32'h2000_0040, 2);

      // 4: wrap at FFC, unaligned branch target
      accept(1'b1, 12'hFFC, 12'hFFC);
      fetch_hold(12'hFFC, 32'h2000_0FFC, 1);
      accept(1'b0, 12'h000, 12'h000);
      fetch_hold(12'h000, 32'h2000_0000, 1);
      accept(1'b1, 12'h013, 12'h013);
      fetch_hold(12'h013, 32'h2000_0013, 1);

      // 5: halt opcode at 020
      accept(1'b1, 12'h020, 12'h020);
      tick();
      imemAck = 1'b1;
      imemData = HALT_WORD;
      tick();
      imemAck = 1'b0;
      check("t5_instr", instr, HALT_WORD);
      instrReady = 1'b1;
      imemAck = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t5_halted", 32'(halted), 32'd1);
         check("t5_req", 32'(imemReq), 32'd0);
         check("t5_valid", 32'(instrValid), 32'd0);
         tick();
      end
      imemAck = 1'b0;
      instrReady = 1'b0;

      // 6: async reset in WAIT, stray ack after release
      do_reset();
      check("t6_halt_cleared", 32'(halted), 32'd0);
      imemAck = 1'b1;
      imemData = 32'h3000_0000;
      tick();
      imemAck = 1'b0;
      accept(1'b0, 12'h000, 12'h004);
      tick();
      check("t6_wait_req", 32'(imemReq), 32'd1);
      check("t6_wait_addr", 32'(imemAddr), 32'h004);
      #2;
      rst = 1'b0;
      #1;
      check("t6_async_req", 32'(imemReq), 32'd0);
      check("t6_async_pc", 32'(pc), 32'h000);
      check("t6_async_addr", 32'(imemAddr), 32'h000);
      imemAck = 1'b1;
      imemData = 32'h0BAD_0BAD;
      @(negedge clk);
      rst = 1'b1;
      tick();
      imemAck = 1'b0;
      check("t6_stray_valid", 32'(instrValid), 32'd0);
      check("t6_stray_instr", instr, 32'h0);
      check("t6_stray_req", 32'(imemReq), 32'd1);
      imemAck = 1'b1;
      imemData = 32'h3000_0100;
      tick();
      imemAck = 1'b0;
      check("t6_resume_pc", 32'(pc), 32'h000);
      check("t6_resume_instr", instr, 32'h3000_0100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
